// File: rtl/ec_pkg.sv
// Shared types and default geometry for the erasure-code engine and its mask loader.
package ec_pkg;
    localparam int EC_W             = 4;
    localparam int EC_K_MAX         = 128;
    localparam int EC_PACKET_LENGTH = 2;

    typedef logic [EC_K_MAX-1:0] row_t;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } ldr_state_e;
endpackage

// File: rtl/mask_row_expand.sv
// One matrix row to per-packet mask cells: columns at or beyond k_eff are zeroed,
// each surviving bit is replicated across the packet lanes.
module mask_row_expand
    import ec_pkg::*;
#(
    parameter int K_MAX         = EC_K_MAX,
    parameter int PACKET_LENGTH = EC_PACKET_LENGTH,
    parameter int KW            = $clog2(K_MAX + 1)
) (
    input  logic [K_MAX-1:0]                    row,
    input  logic [KW-1:0]                       k_eff,
    output logic [PACKET_LENGTH-1:0][0:K_MAX-1] cells
);
    for (genvar j = 0; j < K_MAX; j++) begin : g_col
        localparam logic [KW-1:0] COL = KW'(j);
        logic keep;
        assign keep = row[j] & (COL < k_eff);
        for (genvar p = 0; p < PACKET_LENGTH; p++) begin : g_rep
            assign cells[p][j] = keep;
        end
    end
endmodule

// File: rtl/mask_loader.sv
// Double-buffered mask loader: rows fill a shadow matrix, which is expanded and
// committed to the active mask only while the engine reports idle.
module mask_loader
    import ec_pkg::*;
#(
    parameter int   W             = EC_W,
    parameter int   K_MAX         = EC_K_MAX,
    parameter int   PACKET_LENGTH = EC_PACKET_LENGTH,
    localparam int  KW            = $clog2(K_MAX + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [K_MAX-1:0]                            cfg_row,
    input  logic                                        cfg_last,
    input  logic [KW-1:0]                               k_cfg,
    input  logic                                        eng_idle,
    input  logic                                        mask_clear,
    output logic [PACKET_LENGTH-1:0][0:W-1][0:K_MAX-1]  mask,
    output logic                                        mask_valid,
    output logic                                        mask_updated,
    output logic                                        err_len
);
    localparam int RW = (W > 1) ? $clog2(W) : 1;

    ldr_state_e state, state_nxt;
    logic [RW-1:0]               row_cnt;
    logic [0:W-1][K_MAX-1:0]     shadow;
    logic                        accept, last_row, frame_err, commit;
    logic [KW-1:0]               k_eff;

    logic [0:W-1][PACKET_LENGTH-1:0][0:K_MAX-1]   row_cells;
    logic [PACKET_LENGTH-1:0][0:W-1][0:K_MAX-1]   mask_nxt;

    assign k_eff = (k_cfg > KW'(K_MAX)) ? KW'(K_MAX) : k_cfg;

    for (genvar i = 0; i < W; i++) begin : g_row
        mask_row_expand #(
            .K_MAX        (K_MAX),
            .PACKET_LENGTH(PACKET_LENGTH),
            .KW           (KW)
        ) u_expand (
            .row  (shadow[i]),
            .k_eff(k_eff),
            .cells(row_cells[i])
        );
        for (genvar p = 0; p < PACKET_LENGTH; p++) begin : g_lane
            assign mask_nxt[p][i] = row_cells[i][p];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mask_clear) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (accept && cfg_last && last_row) state_nxt = PENDING;
                PENDING: if (eng_idle)                       state_nxt = FILL;
                default:                                     state_nxt = FILL;
            endcase
        end
    end

    // Clear and reset both suppress ready so no row can slip in that cycle.
    always_comb begin
        cfg_ready = rst_n && !mask_clear && (state == FILL);
        accept    = cfg_valid && cfg_ready;
        last_row  = (row_cnt == RW'(W - 1));
        frame_err = accept && (cfg_last != last_row);
        commit    = rst_n && !mask_clear && (state == PENDING) && eng_idle;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || mask_clear) begin
            row_cnt      <= '0;
            shadow       <= '0;
            mask         <= '0;
            mask_valid   <= 1'b0;
            mask_updated <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            mask_updated <= commit;
            err_len      <= frame_err;
            if (accept) begin
                if (frame_err) begin
                    row_cnt <= '0;
                    shadow  <= '0;
                end else begin
                    shadow[row_cnt] <= cfg_row;
                    row_cnt         <= last_row ? '0 : row_cnt + RW'(1);
                end
            end
            if (commit) begin
                mask       <= mask_nxt;
                mask_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mask_loader.sv
// Directed bench for mask_loader (W=4, K_MAX=8, PACKET_LENGTH=2) with a commit scoreboard.
module tb_mask_loader;
    localparam int W  = 4;
    localparam int K  = 8;
    localparam int PL = 2;
    localparam int KW = $clog2(K + 1);

    typedef logic [PL-1:0][0:W-1][0:K-1] mask_t;

    logic            clk = 1'b0;
    logic            rst_n, cfg_valid, cfg_ready, cfg_last, eng_idle, mask_clear;
    logic [K-1:0]    cfg_row;
    logic [KW-1:0]   k_cfg;
    mask_t           mask;
    logic            mask_valid, mask_updated, err_len;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;
    mask_t exp_q[$];

    mask_loader #(.W(W), .K_MAX(K), .PACKET_LENGTH(PL)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_row(cfg_row), .cfg_last(cfg_last), .k_cfg(k_cfg), .eng_idle(eng_idle),
        .mask_clear(mask_clear), .mask(mask), .mask_valid(mask_valid),
        .mask_updated(mask_updated), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic mask_t model(input logic [0:3][7:0] rows, input int k);
        mask_t m;
        int ke = (k > K) ? K : k;
        for (int p = 0; p < PL; p++)
            for (int i = 0; i < W; i++)
                for (int j = 0; j < K; j++)
                    m[p][i][j] = rows[i][j] && (j < ke);
        return m;
    endfunction

    // Present one row and hold it until accepted; optional idle gap with junk data.
    task automatic send_row(input logic [7:0] r, input logic last, input int gap);
        int t = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_row = r; cfg_last = last;
        while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
        chk("ready_timeout", 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_last = 1'b0; cfg_row = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic load(input logic [0:3][7:0] rows, input int k, input int gap, input bit push);
        k_cfg = KW'(k);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1 && push) exp_q.push_back(model(rows, k));
            send_row(rows[i], (i == W - 1), gap);
        end
    endtask

    task automatic wait_update();
        int t = 0;
        do begin @(negedge clk); t++; end while (!mask_updated && t < 20);
        chk("update_timeout", 64'(mask_updated), 64'd1);
    endtask

    // Scoreboard: every mask_updated pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n && mask_updated) begin
            if (exp_q.size() == 0) chk("upd_without_expect", 64'(mask_updated), 64'd0);
            else begin
                chk("commit_mask", 64'(mask), 64'(exp_q.pop_front()));
                chk("commit_valid", 64'(mask_valid), 64'd1);
            end
        end
        if (err_len) chk("upd_during_err", 64'(mask_updated), 64'd0);
    end

    initial begin
        logic [0:3][7:0] ra, rb;
        mask_t exp_a, exp_b;
        ra = {8'hA5, 8'h0F, 8'hF0, 8'hFF};
        rb = {8'h3C, 8'h81, 8'h7E, 8'h00};
        exp_a = model(ra, 8);
        exp_b = model(rb, 8);
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_row = '0; cfg_last = 1'b0;
        k_cfg = KW'(8); eng_idle = 1'b1; mask_clear = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_mask", 64'(mask), 64'd0);
        chk("rst_valid", 64'(mask_valid), 64'd0);
        chk("rst_upd", 64'(mask_updated), 64'd0);
        chk("rst_err", 64'(err_len), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(cfg_ready), 64'd1);

        // basic load and commit latency
        load(ra, 8, 0, 1'b1);
        @(negedge clk);
        chk("upd_lat1", 64'(mask_updated), 64'd0);
        @(negedge clk);
        chk("upd_lat2", 64'(mask_updated), 64'd1);
        chk("cell00", 64'({mask[1][0][0], mask[0][0][0]}), 64'd3);
        chk("cell01", 64'({mask[1][0][1], mask[0][0][1]}), 64'd0);
        @(negedge clk);
        chk("upd_one_cycle", 64'(mask_updated), 64'd0);
        chk("valid_hold", 64'(mask_valid), 64'd1);

        // column gating and clamping
        load(ra, 4, 0, 1'b1);
        wait_update();
        chk("gate_c7", 64'({mask[1][3][7], mask[0][3][7]}), 64'd0);
        chk("gate_c4", 64'({mask[1][3][4], mask[0][3][4]}), 64'd0);
        chk("gate_c3", 64'({mask[1][3][3], mask[0][3][3]}), 64'd3);
        load(ra, 15, 0, 1'b1);
        wait_update();
        chk("clamp_k15", 64'(mask), 64'(exp_a));

        // commit held off while engine busy
        eng_idle = 1'b0;
        load(rb, 8, 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_ready", 64'(cfg_ready), 64'd0);
            chk("hold_mask", 64'(mask), 64'(exp_a));
            chk("hold_upd", 64'(mask_updated), 64'd0);
        end
        eng_idle = 1'b1;
        @(negedge clk);
        chk("commit_on_idle", 64'(mask_updated), 64'd1);

        // framing errors: early last, then missing last
        send_row(8'hA5, 1'b0, 0);
        send_row(8'h0F, 1'b1, 0);
        @(negedge clk);
        chk("err_early", 64'(err_len), 64'd1);
        @(negedge clk);
        chk("err_early_pulse", 64'(err_len), 64'd0);
        chk("err_no_commit", 64'(mask), 64'(exp_b));
        for (int i = 0; i < W; i++) send_row(ra[i], 1'b0, 0);
        @(negedge clk);
        chk("err_missing", 64'(err_len), 64'd1);
        @(negedge clk);
        chk("err_missing_pulse", 64'(err_len), 64'd0);
        load(ra, 8, 0, 1'b1);
        wait_update();

        // clear while a matrix is pending
        eng_idle = 1'b0;
        load(rb, 8, 0, 1'b0);
        @(negedge clk);
        mask_clear = 1'b1; cfg_valid = 1'b1; cfg_row = 8'hFF;
        #1;
        chk("clr_ready", 64'(cfg_ready), 64'd0);
        @(negedge clk);
        chk("clr_mask", 64'(mask), 64'd0);
        chk("clr_valid", 64'(mask_valid), 64'd0);
        chk("clr_upd", 64'(mask_updated), 64'd0);
        mask_clear = 1'b0; cfg_valid = 1'b0; eng_idle = 1'b1;
        #1;
        chk("clr_ready_after", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        chk("clr_no_commit", 64'(mask_updated), 64'd0);

        // reset mid-load, then a full matrix loads normally
        send_row(8'hA5, 1'b0, 0);
        send_row(8'h0F, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(cfg_ready), 64'd0);
        @(negedge clk);
        chk("midrst_mask", 64'(mask), 64'd0);
        chk("midrst_valid", 64'(mask_valid), 64'd0);
        chk("midrst_err", 64'(err_len), 64'd0);
        rst_n = 1'b1;
        load(rb, 8, 0, 1'b1);
        wait_update();
        chk("midrst_no_err", 64'(err_len), 64'd0);

        // backpressure gaps with junk on cfg_row
        load(ra, 8, 1, 1'b1);
        wait_update();
        chk("bp_same", 64'(mask), 64'(exp_a));

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mask_loader.md
Name: mask_loader

Overview:
- Producer side of the engine's mask interface. Receives the GF(2) bit-matrix one row per handshake into a shadow buffer.
- Commits the shadow to the active mask only when the engine is idle.
- Drives a stable per-packet mask array (each matrix bit replicated across PACKET_LENGTH) to the engine's mask-AND stage.
- Double buffering lets the next matrix load while the current one is in use.

Parameters:
- W, 4, matrix rows (word width of the code)
- K_MAX, 128, maximum data-packet columns
- PACKET_LENGTH, 2, bits per packet lane; each mask bit is replicated to this width
- KW, $clog2(K_MAX+1), width of k_cfg (local, do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  row-word valid
- cfg_ready  out  1  loader accepts a row this cycle
- cfg_row  in  K_MAX  one matrix row; bit j = column j
- cfg_last  in  1  marks row W-1 of a matrix
- k_cfg  in  KW  active column count; sampled at commit
- eng_idle  in  1  engine not consuming the mask; commit allowed
- mask_clear  in  1  synchronous clear of active and shadow state
- mask  out  [PACKET_LENGTH-1:0] [0:W-1][0:K_MAX-1]  active mask array, same shape as the engine's mask input
- mask_valid  out  1  active mask holds a committed matrix
- mask_updated  out  1  one-cycle pulse in the first cycle a new mask is visible
- err_len  out  1  one-cycle pulse on a malformed matrix (cfg_last misplaced)

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - mask, mask_valid, mask_updated, err_len = 0; cfg_ready = 0 while rst_n=0.
  - Row counter = 0; state = FILL.
  - Reset mid-load discards the partial shadow.
- Row acceptance: a row is accepted when cfg_valid && cfg_ready.
- FILL state: cfg_ready=1. On an accepted row, shadow[row_cnt] <= cfg_row.
  - row_cnt<W-1, cfg_last=0: row_cnt++.
  - row_cnt<W-1, cfg_last=1: early last. err_len pulse next cycle, row_cnt=0, shadow discarded, stay FILL.
  - row_cnt==W-1, cfg_last=1: row_cnt=0, go PENDING.
  - row_cnt==W-1, cfg_last=0: missing last. err_len pulse, row_cnt=0, discard, stay FILL.
- PENDING state: cfg_ready=0. Wait for eng_idle=1.
  - Commit in that cycle. Every cell gets mask[i][j] <= {PACKET_LENGTH{shadow[i][j] & (j < k_eff)}}, with k_eff = min(k_cfg, K_MAX).
  - Also mask_valid<=1, mask_updated<=1 (pulse), then FILL.
- Latency: last row accepted at edge T gives PENDING after T. With eng_idle=1 in that cycle, the new mask and mask_updated are visible after edge T+1, i.e. 2 cycles from last-row accept. Each extra eng_idle=0 cycle adds one cycle.
- The active mask never changes while eng_idle=0. Commit happens only from PENDING.
- k_cfg=0 commits an all-zero mask and still sets mask_valid. k_cfg>K_MAX is clamped to K_MAX.
- mask_clear=1 has priority over everything in the same cycle:
  - mask=0, mask_valid=0, no mask_updated.
  - Shadow and row_cnt cleared, state=FILL.
  - A row presented in the same cycle is not accepted; cfg_ready=0 that cycle.
- cfg_row content must not be sampled unless accepted. cfg_valid may drop mid-matrix with no effect on the counter.
- mask_updated and err_len are never high together.

Decomposition:
- Shared package ec_pkg:
  - row_t (logic [K_MAX-1:0])
  - ldr_state_e {FILL, PENDING}
  - default W/K_MAX/PACKET_LENGTH constants shared with the engine
- One natural combinational sub-module, mask_row_expand. It takes a row_t plus k_eff and produces [PACKET_LENGTH-1:0][0:K_MAX-1], doing the column gating and bit replication.
- mask_loader instantiates W copies of mask_row_expand on the shadow rows and registers the result at commit.

Test Plan (W=4, K_MAX=8, PACKET_LENGTH=2):
- Basic load: rows 0xA5,0x0F,0xF0,0xFF (last on row 3), k_cfg=8, eng_idle=1.
  - mask[0][0]=2'b11, mask[0][1]=2'b00.
  - mask_valid=1; mask_updated high exactly one cycle, 2 cycles after last accept.
- Column gating: same rows with k_cfg=4 → mask[3][7:4]=2'b00, mask[3][3:0]=2'b11. k_cfg=15 behaves as 8.
- Commit hold: eng_idle=0 for 5 cycles after last row.
  - cfg_ready=0 and old mask unchanged for those cycles.
  - Commit on the first eng_idle=1 cycle.
- Framing errors:
  - cfg_last on row 1 → err_len one pulse, no commit.
  - 4 rows with no last → err_len one pulse.
  - A following well-formed matrix then commits correctly.
- Clear and reset:
  - mask_clear during PENDING → mask all-zero, mask_valid=0, no mask_updated, cfg_ready=1 next cycle.
  - rst_n=0 after 2 accepted rows → all outputs 0; a new full matrix loads normally.
- Backpressure gaps: cfg_valid toggled 1/0 every cycle across 4 rows → rows land in order, identical result to the basic load.
